mcpu_mem_il1c_nway: RTL and testbench



---
 rtl/mcpu_mem_il1c_pkg.sv | 20 ++
 rtl/mcpu_mem_il1c_way.sv | 52 +++++
 rtl/mcpu_mem_il1c_nway.sv | 205 ++++++++++++++++++++
 tb/tb_mcpu_mem_il1c_nway.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcpu_mem_il1c_pkg.sv
// mcpu_mem_il1c_pkg: shared line geometry, FSM state type and tag-width helper
// for the N-way instruction L1 cache.
package mcpu_mem_il1c_pkg;

    localparam int LINE_BITS      = 256;
    localparam int LINE_ADDR_BITS = 5;
    localparam int PACKET_BITS    = 128;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WAIT
    } il1c_state_e;

    // Physical page (20 bits) plus the untranslated index bits above the set index.
    function automatic int tag_width(input int sets_log2);
        return 27 - sets_log2;
    endfunction

endpackage

// File: rtl/mcpu_mem_il1c_way.sv
// mcpu_mem_il1c_way: one cache way -- single-port tag and data RAMs with
// registered read, plus the per-set valid bit vector.
module mcpu_mem_il1c_way
    import mcpu_mem_il1c_pkg::*;
#(
    parameter int SETS_LOG2 = 4,
    parameter int TAG_W     = 23
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_flush,
    input  logic [SETS_LOG2-1:0]       i_set,
    input  logic                       i_we,
    input  logic                       i_wvalid,
    input  logic [TAG_W-1:0]           i_wtag,
    input  logic [LINE_BITS-1:0]       i_wdata,
    output logic [TAG_W-1:0]           o_tag,
    output logic [LINE_BITS-1:0]       o_data,
    output logic [(1<<SETS_LOG2)-1:0]  o_valid
);

    localparam int SETS = 1 << SETS_LOG2;

    logic [TAG_W-1:0]     r_tag_mem  [SETS];
    logic [LINE_BITS-1:0] r_data_mem [SETS];
    logic [TAG_W-1:0]     r_tag_q;
    logic [LINE_BITS-1:0] r_data_q;
    logic [SETS-1:0]      r_valid;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_tag_mem[i_set]  <= i_wtag;
            r_data_mem[i_set] <= i_wdata;
        end
        r_tag_q  <= r_tag_mem[i_set];
        r_data_q <= r_data_mem[i_set];
    end

    // A flush on the same edge as a fill wins: the line stays invalid.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[i_set] <= i_wvalid;
        end
    end

    assign o_tag   = r_tag_q;
    assign o_data  = r_data_q;
    assign o_valid = r_valid;

endmodule

// File: rtl/mcpu_mem_il1c_nway.sv
// mcpu_mem_il1c_nway: N-way VIPT instruction L1 cache with per-set round-robin
// replacement and flush; hit/miss counters exist only with MCPU_IL1C_STATS_EN.
//   state | meaning
//   IDLE  | tag compare for the previous accepted request; accepts new requests
//   READ  | line request outstanding at the arbiter, waiting for rvalid
//   WAIT  | fill data returned to fetch from the fill register
module mcpu_mem_il1c_nway
    import mcpu_mem_il1c_pkg::*;
#(
    parameter int WAYS      = 2,
    parameter int SETS_LOG2 = 4
) (
    input  logic                   clkrst_mem_clk,
    input  logic                   clkrst_mem_rst,
    input  logic [31:4]            il1c_addr,
    input  logic                   il1c_re,
    input  logic                   il1c_flush,
    output logic [PACKET_BITS-1:0] il1c_packet,
    output logic                   il1c_ready,
    output logic                   il1c_pf,
    output logic [31:12]           il1c2tlb_addr,
    output logic                   il1c2tlb_re,
    input  logic [31:12]           il1c2tlb_phys_addr,
    input  logic                   il1c2tlb_ready,
    input  logic                   il1c2tlb_pf,
    output logic                   il1c2arb_valid,
    output logic [2:0]             il1c2arb_opcode,
    output logic [31:5]            il1c2arb_addr,
    input  logic [LINE_BITS-1:0]   il1c2arb_rdata,
    input  logic                   il1c2arb_rvalid,
    input  logic                   il1c2arb_stall
`ifdef MCPU_IL1C_STATS_EN
    ,
    output logic [31:0]            il1c_hits,
    output logic [31:0]            il1c_misses
`endif
);

    localparam int SETS  = 1 << SETS_LOG2;
    localparam int TAG_W = tag_width(SETS_LOG2);
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    il1c_state_e            r_state;
    logic [11:4]            r_addr;
    logic                   r_re;
    logic                   r_arb_valid;
    logic [31:5]            r_arb_addr;
    logic [TAG_W-1:0]       r_fill_tag;
    logic [WAY_W-1:0]       r_victim;
    logic                   r_flush_seen;
    logic [PACKET_BITS-1:0] r_fill_pkt;
    logic [WAY_W-1:0]       r_rr [SETS];

    logic [SETS_LOG2-1:0]   w_set_1a;
    logic [SETS_LOG2-1:0]   w_set_rd;
    logic [TAG_W-1:0]       w_tag_1a;
    logic [TAG_W-1:0]       w_tag_q  [WAYS];
    logic [LINE_BITS-1:0]   w_data_q [WAYS];
    logic [SETS-1:0]        w_valid  [WAYS];
    logic [WAYS-1:0]        w_way_valid;
    logic [WAYS-1:0]        w_hit;
    logic [LINE_BITS-1:0]   w_hit_line;
    logic [WAY_W-1:0]       w_victim;
    logic                   w_lookup, w_pf, w_hit_ok, w_miss;
    logic                   w_fill, w_fill_valid;
    logic                   w_unused;

    assign w_set_1a = r_addr[5 +: SETS_LOG2];
    assign w_set_rd = il1c_ready ? il1c_addr[5 +: SETS_LOG2] : w_set_1a;
    assign w_tag_1a = TAG_W'({il1c2tlb_phys_addr, r_addr[11:5]} >> SETS_LOG2);

    assign w_fill       = (r_state == READ) && il1c2arb_rvalid;
    assign w_fill_valid = !r_flush_seen && !il1c_flush;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        mcpu_mem_il1c_way #(
            .SETS_LOG2 (SETS_LOG2),
            .TAG_W     (TAG_W)
        ) u_way (
            .i_clk    (clkrst_mem_clk),
            .i_rst    (clkrst_mem_rst),
            .i_flush  (il1c_flush),
            .i_set    (w_set_rd),
            .i_we     (w_fill && (r_victim == WAY_W'(w)) && !clkrst_mem_rst),
            .i_wvalid (w_fill_valid),
            .i_wtag   (r_fill_tag),
            .i_wdata  (il1c2arb_rdata),
            .o_tag    (w_tag_q[w]),
            .o_data   (w_data_q[w]),
            .o_valid  (w_valid[w])
        );
        assign w_way_valid[w] = w_valid[w][w_set_1a];
        assign w_hit[w]       = w_way_valid[w] && (w_tag_q[w] == w_tag_1a);
    end

    always_comb begin
        w_hit_line = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (w_hit[w]) w_hit_line = w_hit_line | w_data_q[w];
        end
    end

    // Lowest invalid way first, otherwise the set's round-robin pointer.
    always_comb begin
        w_victim = r_rr[w_set_1a];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!w_way_valid[w]) w_victim = WAY_W'(w);
        end
    end

    assign w_lookup = (r_state == IDLE) && r_re && il1c2tlb_ready;
    assign w_pf     = w_lookup && il1c2tlb_pf;
    assign w_hit_ok = w_lookup && !il1c2tlb_pf && (|w_hit);
    assign w_miss   = w_lookup && !il1c2tlb_pf && !(|w_hit);

    always_comb begin
        il1c_ready = 1'b0;
        case (r_state)
            IDLE:    il1c_ready = !r_re || w_pf || w_hit_ok;
            READ:    il1c_ready = 1'b0;
            WAIT:    il1c_ready = 1'b1;
            default: il1c_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clkrst_mem_clk) begin
        if (clkrst_mem_rst) begin
            r_state      <= IDLE;
            r_re         <= 1'b0;
            r_arb_valid  <= 1'b0;
            r_flush_seen <= 1'b0;
        end else begin
            if (il1c_ready) begin
                r_re   <= il1c_re;
                r_addr <= il1c_addr[11:4];
            end
            case (r_state)
                IDLE: begin
                    if (w_miss) begin
                        r_state      <= READ;
                        r_arb_valid  <= 1'b1;
                        r_arb_addr   <= {il1c2tlb_phys_addr, r_addr[11:5]};
                        r_fill_tag   <= w_tag_1a;
                        r_victim     <= w_victim;
                        r_flush_seen <= 1'b0;
                    end
                end
                READ: begin
                    if (il1c_flush) r_flush_seen <= 1'b1;
                    if (il1c2arb_rvalid) begin
                        r_state     <= WAIT;
                        r_arb_valid <= 1'b0;
                        r_fill_pkt  <= r_addr[4] ? il1c2arb_rdata[LINE_BITS-1:PACKET_BITS]
                                                 : il1c2arb_rdata[PACKET_BITS-1:0];
                    end
                end
                WAIT:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clkrst_mem_clk) begin
        if (clkrst_mem_rst || il1c_flush) begin
            for (int s = 0; s < SETS; s++) r_rr[s] <= '0;
        end else if (w_fill && w_fill_valid) begin
            r_rr[w_set_1a] <= (r_rr[w_set_1a] == WAY_W'(WAYS - 1)) ? '0 : r_rr[w_set_1a] + 1'b1;
        end
    end

    always_ff @(posedge clkrst_mem_clk) begin
        if (!clkrst_mem_rst && w_lookup) assert ($onehot0(w_hit));
    end

`ifdef MCPU_IL1C_STATS_EN
    logic [31:0] r_hits;
    logic [31:0] r_misses;

    always_ff @(posedge clkrst_mem_clk) begin
        if (clkrst_mem_rst) begin
            r_hits   <= '0;
            r_misses <= '0;
        end else begin
            if (w_hit_ok) r_hits   <= r_hits + 32'd1;
            if (w_miss)   r_misses <= r_misses + 32'd1;
        end
    end

    assign il1c_hits   = r_hits;
    assign il1c_misses = r_misses;
`endif

    // The request is simply held until rvalid, so backpressure needs no logic here.
    assign w_unused = il1c2arb_stall;

    assign il1c_packet     = (r_state == WAIT) ? r_fill_pkt
                           : (r_addr[4] ? w_hit_line[LINE_BITS-1:PACKET_BITS] : w_hit_line[PACKET_BITS-1:0]);
    assign il1c_pf         = w_pf;
    assign il1c2tlb_addr   = il1c_addr[31:12];
    assign il1c2tlb_re     = il1c_re && il1c_ready && !clkrst_mem_rst;
    assign il1c2arb_valid  = r_arb_valid;
    assign il1c2arb_opcode = 3'b000;
    assign il1c2arb_addr   = r_arb_addr;

endmodule

// File: tb/tb_mcpu_mem_il1c_nway.sv
// tb_mcpu_mem_il1c_nway: directed bench for the N-way IL1 cache; the TLB maps
// virtual page p to physical page p+1 and the arbiter is driven by hand.
module tb_mcpu_mem_il1c_nway;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:4]  il1c_addr;
    logic         il1c_re;
    logic         il1c_flush;
    logic [127:0] il1c_packet;
    logic         il1c_ready;
    logic         il1c_pf;
    logic [31:12] il1c2tlb_addr;
    logic         il1c2tlb_re;
    logic [31:12] il1c2tlb_phys_addr;
    logic         il1c2tlb_ready;
    logic         il1c2tlb_pf;
    logic         il1c2arb_valid;
    logic [2:0]   il1c2arb_opcode;
    logic [31:5]  il1c2arb_addr;
    logic [255:0] il1c2arb_rdata;
    logic         il1c2arb_rvalid;
    logic         il1c2arb_stall;
`ifdef MCPU_IL1C_STATS_EN
    logic [31:0]  il1c_hits;
    logic [31:0]  il1c_misses;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [31:12] tb_va = '0;

    always #5 clk = ~clk;

    always @(posedge clk) if (il1c2tlb_re) tb_va <= il1c2tlb_addr;
    assign il1c2tlb_phys_addr = tb_va + 20'h1;

    mcpu_mem_il1c_nway #(.WAYS(2), .SETS_LOG2(4)) dut (
        .clkrst_mem_clk     (clk),
        .clkrst_mem_rst     (rst),
        .il1c_addr          (il1c_addr),
        .il1c_re            (il1c_re),
        .il1c_flush         (il1c_flush),
        .il1c_packet        (il1c_packet),
        .il1c_ready         (il1c_ready),
        .il1c_pf            (il1c_pf),
        .il1c2tlb_addr      (il1c2tlb_addr),
        .il1c2tlb_re        (il1c2tlb_re),
        .il1c2tlb_phys_addr (il1c2tlb_phys_addr),
        .il1c2tlb_ready     (il1c2tlb_ready),
        .il1c2tlb_pf        (il1c2tlb_pf),
        .il1c2arb_valid     (il1c2arb_valid),
        .il1c2arb_opcode    (il1c2arb_opcode),
        .il1c2arb_addr      (il1c2arb_addr),
        .il1c2arb_rdata     (il1c2arb_rdata),
        .il1c2arb_rvalid    (il1c2arb_rvalid),
        .il1c2arb_stall     (il1c2arb_stall)
`ifdef MCPU_IL1C_STATS_EN
        ,
        .il1c_hits          (il1c_hits),
        .il1c_misses        (il1c_misses)
`endif
    );

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] half(input logic [31:0] a, input logic [255:0] line);
        return a[4] ? line[255:128] : line[127:0];
    endfunction

    task automatic issue(input logic [31:0] a);
        il1c_addr = a[31:4];
        il1c_re   = 1'b1;
        #1;
        check("accept_ready", il1c_ready, 1);
        check("tlb_re", il1c2tlb_re, 1);
        check("tlb_addr", il1c2tlb_addr, a[31:12]);
        tick();
        il1c_re = 1'b0;
        #1;
    endtask

    task automatic do_hit(input logic [31:0] a, input logic [255:0] line);
        issue(a);
        check("hit_ready", il1c_ready, 1);
        check("hit_pkt", il1c_packet, half(a, line));
        check("hit_no_arb", il1c2arb_valid, 0);
        tick();
    endtask

    // fl: 0 none, 1 flush pulse early in READ, 2 flush on the fill edge
    task automatic do_miss(input logic [31:0] a, input logic [255:0] line, input int lat, input int fl);
        int n;
        issue(a);
        check("miss_stall", il1c_ready, 0);
        n = 0;
        while (!il1c2arb_valid && n < 10) begin
            tick();
            n++;
        end
        check("arb_req", il1c2arb_valid, 1);
        check("arb_addr", il1c2arb_addr, {a[31:12] + 20'h1, a[11:5]});
        check("arb_opcode", il1c2arb_opcode, 0);
        for (int i = 0; i < lat; i++) begin
            il1c2arb_stall = (i == 0);
            il1c_flush     = (fl == 1) && (i == 0);
            tick();
        end
        il1c2arb_stall = 1'b0;
        il1c_flush     = 1'b0;
        check("arb_held", il1c2arb_valid, 1);
        check("read_stall", il1c_ready, 0);
        il1c2arb_rvalid = 1'b1;
        il1c2arb_rdata  = line;
        il1c_flush      = (fl == 2);
        tick();
        il1c2arb_rvalid = 1'b0;
        il1c_flush      = 1'b0;
        check("wait_pkt", il1c_packet, half(a, line));
        check("wait_ready", il1c_ready, 1);
        check("arb_drop", il1c2arb_valid, 0);
        tick();
    endtask

    localparam logic [255:0] L1 = {128'h1111_2222_3333_4444_5555_6666_7777_8888, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210};
    localparam logic [255:0] LA = {128'haaaa_0001_aaaa_0002_aaaa_0003_aaaa_0004, 128'haaaa_1001_aaaa_1002_aaaa_1003_aaaa_1004};
    localparam logic [255:0] LB = {128'hbbbb_0001_bbbb_0002_bbbb_0003_bbbb_0004, 128'hbbbb_1001_bbbb_1002_bbbb_1003_bbbb_1004};
    localparam logic [255:0] LC = {128'hcccc_0001_cccc_0002_cccc_0003_cccc_0004, 128'hcccc_1001_cccc_1002_cccc_1003_cccc_1004};
    localparam logic [255:0] LD = {128'hdddd_0001_dddd_0002_dddd_0003_dddd_0004, 128'hdddd_1001_dddd_1002_dddd_1003_dddd_1004};
    localparam logic [255:0] LE = {128'heeee_0001_eeee_0002_eeee_0003_eeee_0004, 128'heeee_1001_eeee_1002_eeee_1003_eeee_1004};
    localparam logic [255:0] LF = {128'hffff_0001_ffff_0002_ffff_0003_ffff_0004, 128'hffff_1001_ffff_1002_ffff_1003_ffff_1004};

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst             = 1'b1;
        il1c_addr       = '0;
        il1c_re         = 1'b0;
        il1c_flush      = 1'b0;
        il1c2tlb_ready  = 1'b1;
        il1c2tlb_pf     = 1'b0;
        il1c2arb_rdata  = '0;
        il1c2arb_rvalid = 1'b0;
        il1c2arb_stall  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;

        check("rst_ready", il1c_ready, 1);
        check("rst_arb_valid", il1c2arb_valid, 0);
        check("rst_pf", il1c_pf, 0);
        check("rst_tlb_re", il1c2tlb_re, 0);
`ifdef MCPU_IL1C_STATS_EN
        check("rst_hits", il1c_hits, 0);
        check("rst_misses", il1c_misses, 0);
`endif

        // cold miss, then hit on the upper half of the same line
        do_miss(32'h0000_1000, L1, 3, 0);
        do_hit(32'h0000_1010, L1);

        // three pages aliasing set 1 with two ways
        do_miss(32'h0001_0020, LA, 1, 0);
        do_miss(32'h0002_0020, LB, 2, 0);
        do_miss(32'h0003_0020, LC, 1, 0);
        do_hit(32'h0002_0020, LB);
        do_hit(32'h0003_0030, LC);
        do_miss(32'h0001_0020, LA, 1, 0);
        do_hit(32'h0003_0020, LC);
        do_miss(32'h0002_0030, LB, 1, 0);
        do_hit(32'h0000_1000, L1);

        // page fault on a miss
        il1c2tlb_pf = 1'b1;
        issue(32'h0000_5000);
        check("pf_flag", il1c_pf, 1);
        check("pf_ready", il1c_ready, 1);
        check("pf_no_arb", il1c2arb_valid, 0);
        tick();
        il1c2tlb_pf = 1'b0;
        #1;
        check("pf_no_arb_later", il1c2arb_valid, 0);
        check("pf_clear", il1c_pf, 0);

        // TLB not ready stalls the lookup
        il1c2tlb_ready = 1'b0;
        issue(32'h0000_1000);
        check("tlb_stall", il1c_ready, 0);
        tick();
        check("tlb_stall_hold", il1c_ready, 0);
        il1c2tlb_ready = 1'b1;
        #1;
        check("tlb_resume_ready", il1c_ready, 1);
        check("tlb_resume_pkt", il1c_packet, L1[127:0]);
        tick();

        // flush during READ returns data but leaves the line invalid
        do_miss(32'h0000_7000, LD, 3, 1);
        do_miss(32'h0000_7000, LE, 1, 2);
        do_miss(32'h0000_7000, LE, 1, 0);
        do_hit(32'h0000_7010, LE);
        do_miss(32'h0000_1000, L1, 1, 0);

        // reset in READ with a late rvalid
        issue(32'h0000_9000);
        n = 0;
        while (!il1c2arb_valid && n < 10) begin
            tick();
            n++;
        end
        check("rstmid_arb_req", il1c2arb_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rstmid_arb_drop", il1c2arb_valid, 0);
        check("rstmid_ready", il1c_ready, 1);
        tick();
        il1c2arb_rvalid = 1'b1;
        il1c2arb_rdata  = LF;
        tick();
        il1c2arb_rvalid = 1'b0;
        #1;
        check("late_rvalid_ready", il1c_ready, 1);
        check("late_rvalid_arb", il1c2arb_valid, 0);
        do_miss(32'h0000_9000, LF, 1, 0);

        // 3 misses then 5 hits after a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        do_miss(32'h0000_A000, LA, 1, 0);
        do_miss(32'h0000_A020, LB, 1, 0);
        do_miss(32'h0000_A040, LC, 1, 0);
        do_hit(32'h0000_A000, LA);
        do_hit(32'h0000_A010, LA);
        do_hit(32'h0000_A020, LB);
        do_hit(32'h0000_A030, LB);
        do_hit(32'h0000_A040, LC);
`ifdef MCPU_IL1C_STATS_EN
        check("stat_misses", il1c_misses, 3);
        check("stat_hits", il1c_hits, 5);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
